// File: rtl/result_pkg.sv
// result_pkg: shared defaults, frame state and return-entry layout for result_dispatch.
package result_pkg;
  localparam int DW_DEF = 32;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} frame_state_t;
  typedef struct packed {
    logic last;
    logic [1:0] mode;
    logic [DW_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/ret_fifo.sv
// ret_fifo: first-word-fall-through return queue, no same-cycle pop bypass on full.
module ret_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  output logic full,
  output logic rvalid,
  input  logic rready,
  output T     dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic wr, pop;
  assign full = cnt == CW'(DEPTH);
  assign rvalid = cnt != '0;
  assign dout = mem[rd_ptr];
  assign wr = push && !full;
  assign pop = rvalid && rready;
  // storage is cleared on reset so the head reads zero until the first push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) mem[wr_ptr] <= din;
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end
endmodule

// File: rtl/result_dispatch.sv
// result_dispatch: routes core result words into per-slave return FIFOs and tracks frame completion.
module result_dispatch
  import result_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic          res_src,
  input  logic [1:0]    res_mode,
  input  logic [DW-1:0] res_data,
  input  logic          res_last,
  output logic          slv0_rvalid,
  output logic [DW-1:0] slv0_rdata,
  output logic [1:0]    slv0_rmode,
  output logic          slv0_rlast,
  input  logic          slv0_rready,
  output logic          slv1_rvalid,
  output logic [DW-1:0] slv1_rdata,
  output logic [1:0]    slv1_rmode,
  output logic          slv1_rlast,
  input  logic          slv1_rready,
  output logic          mstr0_cmplt,
  output logic          cmplt_src,
  output logic [15:0]   frame_words
);
  typedef struct packed {
    logic last;
    logic [1:0] mode;
    logic [DW-1:0] data;
  } res_entry_t;
  res_entry_t din, dout0, dout1;
  frame_state_t state;
  logic full0, full1, acc, pop0, pop1, last_pop;
  assign din = '{last: res_last, mode: res_mode, data: res_data};
  assign res_ready = rst_n && (state == IDLE || state == ACTIVE) && !(res_src ? full1 : full0);
  assign acc = res_valid && res_ready;
  assign pop0 = slv0_rvalid && slv0_rready;
  assign pop1 = slv1_rvalid && slv1_rready;
  assign last_pop = (pop0 && dout0.last) || (pop1 && dout1.last);
  assign {slv0_rlast, slv0_rmode, slv0_rdata} = dout0;
  assign {slv1_rlast, slv1_rmode, slv1_rdata} = dout1;
  ret_fifo #(.DEPTH(DEPTH), .T(res_entry_t)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(acc && !res_src), .din(din), .full(full0),
    .rvalid(slv0_rvalid), .rready(slv0_rready), .dout(dout0)
  );
  ret_fifo #(.DEPTH(DEPTH), .T(res_entry_t)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(acc && res_src), .din(din), .full(full1),
    .rvalid(slv1_rvalid), .rready(slv1_rready), .dout(dout1)
  );
  // only the current frame's last word can be queued with last=1, so any last pop ends DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mstr0_cmplt <= 1'b0;
      cmplt_src <= 1'b0;
      frame_words <= '0;
    end else begin
      mstr0_cmplt <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          state <= res_last ? DRAIN : ACTIVE;
          frame_words <= 16'd1;
        end
        ACTIVE: if (acc) begin
          state <= res_last ? DRAIN : ACTIVE;
          frame_words <= frame_words == 16'hFFFF ? frame_words : frame_words + 16'd1;
        end
        DRAIN: if (last_pop) begin
          state <= DONE;
          mstr0_cmplt <= 1'b1;
          cmplt_src <= pop1 && dout1.last;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_dispatch.sv
// tb_result_dispatch: directed vectors with hand-computed expectations for result_dispatch.
module tb_result_dispatch;
  logic clk = 1'b0, rst_n;
  logic res_valid, res_ready, res_src, res_last;
  logic [1:0] res_mode;
  logic [31:0] res_data;
  logic slv0_rvalid, slv0_rlast, slv0_rready, slv1_rvalid, slv1_rlast, slv1_rready;
  logic [31:0] slv0_rdata, slv1_rdata;
  logic [1:0] slv0_rmode, slv1_rmode;
  logic mstr0_cmplt, cmplt_src;
  logic [15:0] frame_words;
  int checks = 0, errors = 0, pulses;
  logic [31:0] e;

  always #5 clk = ~clk;

  result_dispatch dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
    .res_mode(res_mode), .res_data(res_data), .res_last(res_last),
    .slv0_rvalid(slv0_rvalid), .slv0_rdata(slv0_rdata), .slv0_rmode(slv0_rmode),
    .slv0_rlast(slv0_rlast), .slv0_rready(slv0_rready),
    .slv1_rvalid(slv1_rvalid), .slv1_rdata(slv1_rdata), .slv1_rmode(slv1_rmode),
    .slv1_rlast(slv1_rlast), .slv1_rready(slv1_rready),
    .mstr0_cmplt(mstr0_cmplt), .cmplt_src(cmplt_src), .frame_words(frame_words)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d, input logic l);
    res_valid = v;
    res_src = s;
    res_data = d;
    res_mode = d[1:0];
    res_last = l;
  endtask

  initial begin
    rst_n = 1'b0;
    slv0_rready = 1'b0;
    slv1_rready = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    chk("rst_ready", res_ready, 0);
    chk("rst_rvalid0", slv0_rvalid, 0);
    chk("rst_rvalid1", slv1_rvalid, 0);
    chk("rst_rdata0", slv0_rdata, 0);
    chk("rst_cmplt", mstr0_cmplt, 0);
    chk("rst_src", cmplt_src, 0);
    chk("rst_fw", frame_words, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // single-word frame
    slv0_rready = 1'b1;
    drive(1, 0, 32'hA5A5A5A5, 1);
    #1 chk("t1_ready", res_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("t1_rvalid", slv0_rvalid, 1);
    chk("t1_rdata", slv0_rdata, 32'hA5A5A5A5);
    chk("t1_rmode", slv0_rmode, 1);
    chk("t1_rlast", slv0_rlast, 1);
    chk("t1_drain_ready", res_ready, 0);
    chk("t1_fw", frame_words, 1);
    chk("t1_early_cmplt", mstr0_cmplt, 0);
    @(negedge clk);
    #1;
    chk("t1_cmplt", mstr0_cmplt, 1);
    chk("t1_src", cmplt_src, 0);
    chk("t1_empty", slv0_rvalid, 0);
    chk("t1_done_ready", res_ready, 0);
    @(negedge clk);
    #1;
    chk("t1_cmplt_off", mstr0_cmplt, 0);
    chk("t1_fw_hold", frame_words, 1);
    chk("t1_idle_ready", res_ready, 1);
    slv0_rready = 1'b0;
    // push FIFO0 while popping FIFO1 in the same cycle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, 1, 32'h30 + 32'(i), 0);
      #1 chk("t4_pre_ready", res_ready, 1);
    end
    @(negedge clk);
    drive(1, 0, 32'h40, 0);
    slv1_rready = 1'b1;
    #1;
    chk("t4_push_ready", res_ready, 1);
    chk("t4_head1_a", slv1_rdata, 32'h30);
    @(negedge clk);
    drive(0, 0, 0, 0);
    slv1_rready = 1'b0;
    #1;
    chk("t4_rvalid0", slv0_rvalid, 1);
    chk("t4_head0", slv0_rdata, 32'h40);
    chk("t4_rvalid1", slv1_rvalid, 1);
    chk("t4_head1_b", slv1_rdata, 32'h31);
    @(negedge clk);
    drive(1, 0, 32'h41, 1);
    slv0_rready = 1'b1;
    #1 chk("t4_last_ready", res_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("t4_head0_last", slv0_rdata, 32'h41);
    chk("t4_rlast0", slv0_rlast, 1);
    chk("t4_head1_c", slv1_rdata, 32'h31);
    chk("t4_drain_ready", res_ready, 0);
    @(negedge clk);
    #1;
    chk("t4_cmplt", mstr0_cmplt, 1);
    chk("t4_src", cmplt_src, 0);
    chk("t4_fw", frame_words, 4);
    chk("t4_other_kept", slv1_rvalid, 1);
    chk("t4_fifo0_empty", slv0_rvalid, 0);
    slv0_rready = 1'b0;
    slv1_rready = 1'b1;
    @(negedge clk);
    slv1_rready = 1'b0;
    #1;
    chk("t4_fifo1_empty", slv1_rvalid, 0);
    chk("t4_cmplt_off", mstr0_cmplt, 0);
    // backpressure on slave1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 1, 32'h10 + 32'(i), 0);
      #1 chk("t2_ready", res_ready, 1);
    end
    @(negedge clk);
    drive(1, 1, 32'h14, 1);
    #1;
    chk("t2_full_ready", res_ready, 0);
    chk("t2_head_a", slv1_rdata, 32'h10);
    @(negedge clk);
    slv1_rready = 1'b1;
    #1;
    chk("t2_no_bypass", res_ready, 0);
    chk("t2_head_b", slv1_rdata, 32'h10);
    @(negedge clk);
    #1;
    chk("t2_ready_after_pop", res_ready, 1);
    chk("t2_head_c", slv1_rdata, 32'h11);
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      e = 32'h10 + 32'(i);
      #1;
      chk("t2_order", slv1_rdata, e);
      chk("t2_mode", slv1_rmode, e[1:0]);
      chk("t2_rlast", slv1_rlast, i == 4);
    end
    @(negedge clk);
    #1;
    chk("t2_cmplt", mstr0_cmplt, 1);
    chk("t2_src", cmplt_src, 1);
    chk("t2_fw", frame_words, 5);
    slv1_rready = 1'b0;
    @(negedge clk);
    #1 chk("t2_cmplt_off", mstr0_cmplt, 0);
    // interleaved six-word frame
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1, logic'(i % 2), 32'h20 + 32'(i), i == 5);
      #1 chk("t3_ready", res_ready, 1);
    end
    @(negedge clk);
    drive(1, 0, 32'h99, 0);
    slv0_rready = 1'b1;
    #1;
    chk("t3_drain_ready", res_ready, 0);
    chk("t3_s0_w0", slv0_rdata, 32'h20);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t3_s0_order", slv0_rdata, 32'h20 + 32'(2 * i));
      chk("t3_s0_ready", res_ready, 0);
    end
    @(negedge clk);
    slv0_rready = 1'b0;
    slv1_rready = 1'b1;
    #1;
    chk("t3_s0_empty", slv0_rvalid, 0);
    chk("t3_still_drain", res_ready, 0);
    chk("t3_s1_w0", slv1_rdata, 32'h21);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t3_s1_order", slv1_rdata, 32'h21 + 32'(2 * i));
      chk("t3_s1_rlast", slv1_rlast, i == 2);
    end
    @(negedge clk);
    slv1_rready = 1'b0;
    #1;
    chk("t3_cmplt", mstr0_cmplt, 1);
    chk("t3_src", cmplt_src, 1);
    chk("t3_fw", frame_words, 6);
    chk("t3_done_ready", res_ready, 0);
    @(negedge clk);
    #1 chk("t3_idle_ready", res_ready, 1);
    drive(0, 0, 0, 0);
    // mid-frame reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, logic'(i % 2), 32'h57 + 32'(i), 0);
      #1 chk("t5_ready", res_ready, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_ready_rst", res_ready, 0);
    chk("t5_rvalid0", slv0_rvalid, 0);
    chk("t5_rdata0", slv0_rdata, 0);
    chk("t5_rmode0", slv0_rmode, 0);
    chk("t5_rlast0", slv0_rlast, 0);
    chk("t5_rvalid1", slv1_rvalid, 0);
    chk("t5_rdata1", slv1_rdata, 0);
    chk("t5_rmode1", slv1_rmode, 0);
    chk("t5_rlast1", slv1_rlast, 0);
    chk("t5_cmplt", mstr0_cmplt, 0);
    chk("t5_src", cmplt_src, 0);
    chk("t5_fw", frame_words, 0);
    @(negedge clk);
    rst_n = 1'b1;
    slv0_rready = 1'b1;
    slv1_rready = 1'b1;
    #1;
    chk("t5_post_rvalid0", slv0_rvalid, 0);
    chk("t5_post_rvalid1", slv1_rvalid, 0);
    chk("t5_post_ready", res_ready, 1);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      #1 pulses += int'(mstr0_cmplt);
    end
    chk("t5_no_cmplt", pulses, 0);
    slv1_rready = 1'b0;
    // frame_words saturation
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      drive(1, 0, 32'(i), i == 65539);
      if (i == 65534) begin
        #1 chk("t6_fw_pre_sat", frame_words, 16'hFFFE);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("t6_fw_sat", frame_words, 16'hFFFF);
    chk("t6_last_head", slv0_rdata, 32'd65539);
    chk("t6_rlast", slv0_rlast, 1);
    @(negedge clk);
    #1;
    chk("t6_cmplt", mstr0_cmplt, 1);
    chk("t6_fw_hold", frame_words, 16'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
